// File: rtl/br_gshare_pred.sv
`default_nettype none
// ============================================================================
// Module   : br_gshare_pred
// Brief    : Gshare branch direction predictor with 2-bit-counter PHT,
//            speculative global history, commit-time training and flush repair.
// Revision : 1.0
// ============================================================================
module br_gshare_pred #(
    parameter  int ADDR = 32,
    parameter  int HIST = 10,
    localparam int ST   = 2*HIST+1
) (
    input  logic            clk,
    input  logic            reset_,
    // fetch-side prediction
    input  logic            pred_br_,
    input  logic [ADDR-1:0] pred_pc,
    output logic            pred_taken,
    output logic            pred_stall,
    // branch status buffer write port
    output logic            st_we_,
    output logic [ST-1:0]   st_wd,
    input  logic            st_busy,
    // commit / training
    input  logic            com_br_,
    input  logic            com_taken,
    input  logic [ST-1:0]   com_status,
    output logic            st_re_,
    // writeback misprediction flush
    input  logic            wb_flush_,
    input  logic            wb_taken,
    input  logic [ST-1:0]   wb_status,
    // performance counters
    output logic [31:0]     perf_br,
    output logic [31:0]     perf_mis
);

    localparam int         PHT_N     = 1 << HIST;
    localparam logic [1:0] CTR_RESET = 2'b01;

    logic [HIST-1:0] ghr_q, ghr_d;
    logic [1:0]      pht_q [PHT_N];
    logic [31:0]     perf_br_q, perf_mis_q;

    logic [HIST-1:0] w_idx;
    logic            w_accept;
    logic [HIST-1:0] w_com_idx;
    logic [1:0]      w_com_ctr;
    logic [1:0]      w_com_ctr_nxt;
    logic            w_com_mis;

    // ------------------------------------------------------------------
    // Fetch-side prediction and status word
    // ------------------------------------------------------------------
    assign w_idx      = pred_pc[HIST+1:2] ^ ghr_q;
    assign pred_taken = pht_q[w_idx][1];

    // A flush owns the history update this cycle, so fetch must retry.
    assign w_accept   = !pred_br_ && !st_busy && wb_flush_;
    assign pred_stall = !pred_br_ && (st_busy || !wb_flush_);

    assign st_we_ = !w_accept;
    assign st_wd  = {w_idx, pred_taken, ghr_q};
    assign st_re_ = com_br_;

    always_comb begin
        ghr_d = ghr_q;
        if (!wb_flush_) begin
            ghr_d = {wb_status[HIST-2:0], wb_taken};
        end else if (w_accept) begin
            ghr_d = {ghr_q[HIST-2:0], pred_taken};
        end
    end

    // ------------------------------------------------------------------
    // Commit-side training
    // ------------------------------------------------------------------
    assign w_com_idx = com_status[2*HIST:HIST+1];
    assign w_com_ctr = pht_q[w_com_idx];
    assign w_com_mis = com_taken != com_status[HIST];

    always_comb begin
        w_com_ctr_nxt = w_com_ctr;
        if (com_taken) begin
            if (w_com_ctr != 2'b11) begin
                w_com_ctr_nxt = w_com_ctr + 2'b01;
            end
        end else begin
            if (w_com_ctr != 2'b00) begin
                w_com_ctr_nxt = w_com_ctr - 2'b01;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            ghr_q      <= '0;
            perf_br_q  <= '0;
            perf_mis_q <= '0;
            for (int i = 0; i < PHT_N; i++) begin
                pht_q[i] <= CTR_RESET;
            end
        end else begin
            ghr_q <= ghr_d;
            if (!com_br_) begin
                pht_q[w_com_idx] <= w_com_ctr_nxt;
                perf_br_q        <= perf_br_q + 32'd1;
                if (w_com_mis) begin
                    perf_mis_q <= perf_mis_q + 32'd1;
                end
            end
        end
    end

    assign perf_br  = perf_br_q;
    assign perf_mis = perf_mis_q;

    // Only the low history bits of the flush status and the index bits of the PC matter.
    logic unused_ok;
    assign unused_ok = ^{wb_status[ST-1:HIST-1], pred_pc[ADDR-1:HIST+2], pred_pc[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_br_gshare_pred.sv
`default_nettype none
// ============================================================================
// Module   : tb_br_gshare_pred
// Brief    : Scoreboard bench for br_gshare_pred with directed vectors.
// Revision : 1.0
// ============================================================================
module tb_br_gshare_pred;

    localparam int ADDR = 32;
    localparam int HIST = 10;
    localparam int ST   = 2*HIST+1;

    logic            clk = 1'b0;
    logic            reset_;
    logic            pred_br_;
    logic [ADDR-1:0] pred_pc;
    logic            pred_taken;
    logic            pred_stall;
    logic            st_we_;
    logic [ST-1:0]   st_wd;
    logic            st_busy;
    logic            com_br_;
    logic            com_taken;
    logic [ST-1:0]   com_status;
    logic            st_re_;
    logic            wb_flush_;
    logic            wb_taken;
    logic [ST-1:0]   wb_status;
    logic [31:0]     perf_br;
    logic [31:0]     perf_mis;

    br_gshare_pred #(.ADDR(ADDR), .HIST(HIST)) dut (
        .clk        (clk),
        .reset_     (reset_),
        .pred_br_   (pred_br_),
        .pred_pc    (pred_pc),
        .pred_taken (pred_taken),
        .pred_stall (pred_stall),
        .st_we_     (st_we_),
        .st_wd      (st_wd),
        .st_busy    (st_busy),
        .com_br_    (com_br_),
        .com_taken  (com_taken),
        .com_status (com_status),
        .st_re_     (st_re_),
        .wb_flush_  (wb_flush_),
        .wb_taken   (wb_taken),
        .wb_status  (wb_status),
        .perf_br    (perf_br),
        .perf_mis   (perf_mis)
    );

    always #5 clk = ~clk;

    int            n_chk  = 0;
    int            n_pass = 0;
    logic [ST-1:0] exp_q [$];
    int            exp_br  = 0;
    int            exp_mis = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every buffer write is matched against the next expected status word.
    always @(negedge clk) begin
        if (reset_ === 1'b1 && st_we_ === 1'b0) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                $display("FAIL st_wd_unexpected: got 0x%0h expected no write", st_wd);
            end else begin
                logic [ST-1:0] e;
                e = exp_q.pop_front();
                if (st_wd === e) n_pass++;
                else $display("FAIL st_wd: got 0x%0h expected 0x%0h", st_wd, e);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic predict(input logic [ADDR-1:0] pc, input logic [HIST-1:0] idx,
                           input logic tk, input logic [HIST-1:0] ghr);
        pred_br_ = 1'b0;
        pred_pc  = pc;
        exp_q.push_back({idx, tk, ghr});
        @(negedge clk);
        chk("pred_taken", {31'd0, pred_taken}, {31'd0, tk});
        cyc();
        pred_br_ = 1'b1;
    endtask

    // Read a prediction without accepting it by holding the buffer busy.
    task automatic peek(input logic [ADDR-1:0] pc, input logic tk);
        pred_br_ = 1'b0;
        pred_pc  = pc;
        st_busy  = 1'b1;
        @(negedge clk);
        chk("peek_taken", {31'd0, pred_taken}, {31'd0, tk});
        chk("peek_stall", {31'd0, pred_stall}, 32'd1);
        cyc();
        pred_br_ = 1'b1;
        st_busy  = 1'b0;
    endtask

    task automatic commit(input logic [HIST-1:0] idx, input logic pbit, input logic tk);
        com_br_    = 1'b0;
        com_status = {idx, pbit, {HIST{1'b0}}};
        com_taken  = tk;
        exp_br++;
        if (tk != pbit) exp_mis++;
        @(negedge clk);
        chk("st_re_", {31'd0, st_re_}, 32'd0);
        cyc();
        com_br_ = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_     = 1'b0;
        pred_br_   = 1'b1;
        pred_pc    = 32'h100;
        st_busy    = 1'b0;
        com_br_    = 1'b1;
        com_taken  = 1'b0;
        com_status = '0;
        wb_flush_  = 1'b1;
        wb_taken   = 1'b0;
        wb_status  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_st_we_", {31'd0, st_we_}, 32'd1);
        chk("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
        chk("rst_perf_br", perf_br, 32'd0);
        chk("rst_perf_mis", perf_mis, 32'd0);
        chk("rst_st_re_", {31'd0, st_re_}, 32'd1);
        cyc();
        reset_ = 1'b1;

        // First prediction after reset
        predict(32'h100, 10'h040, 1'b0, 10'h000);

        // Counter saturation up and down on idx 0x040
        commit(10'h040, 1'b0, 1'b1);
        commit(10'h040, 1'b0, 1'b1);
        peek(32'h100, 1'b1);
        commit(10'h040, 1'b0, 1'b1);
        peek(32'h100, 1'b1);
        commit(10'h040, 1'b0, 1'b0);
        peek(32'h100, 1'b1);
        commit(10'h040, 1'b0, 1'b0);
        peek(32'h100, 1'b0);
        commit(10'h040, 1'b0, 1'b0);
        peek(32'h100, 1'b0);
        commit(10'h040, 1'b0, 1'b1);
        peek(32'h100, 1'b0);
        chk("perf_br_a", perf_br, 32'(exp_br));
        chk("perf_mis_a", perf_mis, 32'(exp_mis));

        // Back-to-back history shifting 1,0,1,1
        commit(10'h010, 1'b0, 1'b1);
        predict(32'h40,  10'h010, 1'b1, 10'h000);
        predict(32'h200, 10'h081, 1'b0, 10'h001);
        predict(32'h48,  10'h010, 1'b1, 10'h002);
        predict(32'h54,  10'h010, 1'b1, 10'h005);
        predict(32'h0,   10'h00B, 1'b0, 10'h00B);

        // Buffer busy stall, then retry
        pred_br_ = 1'b0;
        pred_pc  = 32'h100;
        st_busy  = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("busy_stall", {31'd0, pred_stall}, 32'd1);
            chk("busy_st_we_", {31'd0, st_we_}, 32'd1);
            cyc();
        end
        st_busy = 1'b0;
        predict(32'h100, 10'h056, 1'b0, 10'h016);

        // Flush with concurrent fetch and commit
        wb_flush_  = 1'b0;
        wb_status  = {10'h000, 1'b0, 10'h155};
        wb_taken   = 1'b1;
        pred_br_   = 1'b0;
        pred_pc    = 32'h100;
        com_br_    = 1'b0;
        com_status = {10'h300, 1'b0, 10'h000};
        com_taken  = 1'b1;
        exp_br++;
        exp_mis++;
        @(negedge clk);
        chk("flush_st_we_", {31'd0, st_we_}, 32'd1);
        chk("flush_stall", {31'd0, pred_stall}, 32'd1);
        cyc();
        wb_flush_ = 1'b1;
        pred_br_  = 1'b1;
        com_br_   = 1'b1;
        predict(32'h0, 10'h2AB, 1'b0, 10'h2AB);
        peek(32'h958, 1'b1);
        chk("perf_br_b", perf_br, 32'(exp_br));
        chk("perf_mis_b", perf_mis, 32'(exp_mis));

        // Asynchronous reset mid-cycle
        pred_pc = 32'hC00;
        #3;
        reset_ = 1'b0;
        #1;
        chk("arst_perf_br", perf_br, 32'd0);
        chk("arst_perf_mis", perf_mis, 32'd0);
        chk("arst_pred_taken", {31'd0, pred_taken}, 32'd0);
        chk("arst_st_wd", {11'd0, st_wd}, {11'd0, 10'h300, 1'b0, 10'h000});
        cyc();
        reset_ = 1'b1;

        // Five commits, two mispredicted
        commit(10'h001, 1'b1, 1'b1);
        commit(10'h002, 1'b0, 1'b0);
        commit(10'h003, 1'b0, 1'b1);
        commit(10'h004, 1'b1, 1'b0);
        commit(10'h005, 1'b1, 1'b1);
        @(negedge clk);
        chk("perf_br_5", perf_br, 32'd5);
        chk("perf_mis_2", perf_mis, 32'd2);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
